alu_share_ctrl: RTL and testbench

Round-robin controller that shares a single registered `my_alu` between two requesters. It accepts one operation at a time over a valid/ready handshake, drives the ALU operand and opcode inputs, and waits the ALU's fixed latency. It then returns the result and flags, tagged with the requester ID, over a second valid/ready handshake. It sits between the instruction-issue logic and the ALU datapath.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_share_ctrl_if.sv | 38 +++
 rtl/rr_arb2.sv | 22 ++
 rtl/alu_share_ctrl.sv | 122 ++++++++++++
 tb/tb_alu_share_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: opcodes, FSM state
// encoding, the ALU flag bundle and the controller debug view.
package alu_pkg;

   localparam logic [2:0] OP_ADDU = 3'b000;
   localparam logic [2:0] OP_SUBU = 3'b001;
   localparam logic [2:0] OP_ADDS = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_SHR1 = 3'b111;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_RESP = 2'd2;

   typedef struct packed {
      logic carryout;
      logic overflow;
      logic zero;
   } alu_flags_t;

   typedef struct packed {
      state_t state;
      logic   ptr;
   } dbg_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between the issue logic (master) and the ALU
// sharing controller (slave).
interface alu_share_ctrl_if #(
   parameter int NUMBITS = 8
);
   // Both channels: a transfer happens on a rising edge where valid and ready
   // are both high; a response, once valid, holds its payload until then.
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [NUMBITS-1:0] req_a0;
   logic [NUMBITS-1:0] req_b0;
   logic [NUMBITS-1:0] req_a1;
   logic [NUMBITS-1:0] req_b1;
   logic [2:0]         req_op0;
   logic [2:0]         req_op1;
   logic               rsp_valid;
   logic               rsp_ready;
   logic               rsp_id;
   logic [NUMBITS-1:0] rsp_result;
   logic               rsp_carryout;
   logic               rsp_overflow;
   logic               rsp_zero;

   modport master (
      output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
      input  req_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_zero,
      output rsp_ready
   );

   modport slave (
      input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
      output req_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_zero,
      input  rsp_ready
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; ptr names the requester that wins a tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       ptr
);

   always_comb begin
      grant = req;
      if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
   end

   // The pointer always moves to the requester that did not just win.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       ptr <= 1'b0;
      else if (advance) ptr <= grant[0];
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered ALU between two requesters (IDLE -> WAIT -> RESP).
// Optional 16-bit saturating grant counters: define ALU_SHARE_STATS_EN.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int NUMBITS = 8,
   parameter int ALU_LAT = 1
) (
   input  logic               clk,
   input  logic               reset,
   alu_share_ctrl_if.slave    bus,
   output logic [NUMBITS-1:0] alu_A,
   output logic [NUMBITS-1:0] alu_B,
   output logic [2:0]         alu_opcode,
   input  logic [NUMBITS-1:0] alu_result,
   input  logic               alu_carryout,
   input  logic               alu_overflow,
   input  logic               alu_zero,
   output dbg_t               dbg
`ifdef ALU_SHARE_STATS_EN
   ,
   output logic [15:0]        grant_cnt0,
   output logic [15:0]        grant_cnt1
`endif
);

   localparam logic [2:0] LAT3 = 3'(ALU_LAT);

   state_t     state;
   logic [2:0] cnt;
   logic       id_q;
   logic [1:0] grant;
   logic       ptr;
   logic       accept;
   alu_flags_t alu_flags;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (bus.req_valid & {2{state == ST_IDLE}}),
      .advance (accept),
      .grant   (grant),
      .ptr     (ptr)
   );

   assign accept        = |grant;
   assign bus.req_ready = grant;
   assign alu_flags     = '{carryout: alu_carryout, overflow: alu_overflow, zero: alu_zero};
   assign dbg           = '{state: state, ptr: ptr};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= ST_IDLE;
         cnt              <= '0;
         id_q             <= 1'b0;
         alu_A            <= '0;
         alu_B            <= '0;
         alu_opcode       <= '0;
         bus.rsp_valid    <= 1'b0;
         bus.rsp_id       <= 1'b0;
         bus.rsp_result   <= '0;
         bus.rsp_carryout <= 1'b0;
         bus.rsp_overflow <= 1'b0;
         bus.rsp_zero     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (grant[1]) begin
                     alu_A      <= bus.req_a1;
                     alu_B      <= bus.req_b1;
                     alu_opcode <= bus.req_op1;
                     id_q       <= 1'b1;
                  end else begin
                     alu_A      <= bus.req_a0;
                     alu_B      <= bus.req_b0;
                     alu_opcode <= bus.req_op0;
                     id_q       <= 1'b0;
                  end
                  cnt   <= LAT3;
                  state <= ST_WAIT;
               end
            end
            // One extra WAIT cycle after the count expires lets the ALU
            // output settle before it is sampled.
            ST_WAIT: begin
               if (cnt == 3'd0) begin
                  bus.rsp_result   <= alu_result;
                  bus.rsp_carryout <= alu_flags.carryout;
                  bus.rsp_overflow <= alu_flags.overflow;
                  bus.rsp_zero     <= alu_flags.zero;
                  bus.rsp_id       <= id_q;
                  bus.rsp_valid    <= 1'b1;
                  state            <= ST_RESP;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ALU_SHARE_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (grant[0] && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (grant[1] && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural one-cycle ALU.
// Grant counter checks are compiled in when ALU_SHARE_STATS_EN is defined.
module tb_alu_share_ctrl;
   import alu_pkg::*;

   localparam int W   = 8;
   localparam int LAT = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_share_ctrl_if #(.NUMBITS(W)) bus ();

   logic [W-1:0] alu_A, alu_B, alu_result;
   logic [2:0]   alu_opcode;
   logic         alu_carryout, alu_overflow, alu_zero;
   dbg_t         dbg;
`ifdef ALU_SHARE_STATS_EN
   logic [15:0]  grant_cnt0, grant_cnt1;
`endif

   alu_share_ctrl #(.NUMBITS(W), .ALU_LAT(LAT)) dut (
      .clk          (clk),
      .reset        (rst_n),
      .bus          (bus),
      .alu_A        (alu_A),
      .alu_B        (alu_B),
      .alu_opcode   (alu_opcode),
      .alu_result   (alu_result),
      .alu_carryout (alu_carryout),
      .alu_overflow (alu_overflow),
      .alu_zero     (alu_zero),
      .dbg          (dbg)
`ifdef ALU_SHARE_STATS_EN
      ,
      .grant_cnt0   (grant_cnt0),
      .grant_cnt1   (grant_cnt1)
`endif
   );

   // Behavioural registered ALU standing in for my_alu.
   logic [W:0]   alu_sum;
   logic [W-1:0] r_next;
   logic         c_next, v_next;
   always_comb begin
      alu_sum = {1'b0, alu_A} + {1'b0, alu_B};
      r_next  = '0;
      c_next  = 1'b0;
      v_next  = 1'b0;
      case (alu_opcode)
         OP_ADDU: begin r_next = alu_sum[W-1:0]; c_next = alu_sum[W]; end
         OP_SUBU: begin r_next = alu_A - alu_B; c_next = (alu_A < alu_B); end
         OP_ADDS: begin
            r_next = alu_sum[W-1:0];
            c_next = alu_sum[W];
            v_next = (alu_A[W-1] == alu_B[W-1]) && (alu_sum[W-1] != alu_A[W-1]);
         end
         OP_AND:  r_next = alu_A & alu_B;
         OP_OR:   r_next = alu_A | alu_B;
         OP_XOR:  r_next = alu_A ^ alu_B;
         OP_SHR1: begin r_next = alu_A >> 1; c_next = alu_A[0]; end
         default: r_next = '0;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_result <= '0; alu_carryout <= 1'b0; alu_overflow <= 1'b0; alu_zero <= 1'b0;
      end else begin
         alu_result <= r_next; alu_carryout <= c_next; alu_overflow <= v_next;
         alu_zero <= (r_next == '0);
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (bus.rsp_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.rsp_ready = 1'b1;
      while (!(dbg.state == ST_IDLE && bus.rsp_valid == 1'b0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain_bound", 32'(n < 20), 32'd1);
   endtask

   typedef struct {
      logic       id;
      logic [7:0] a, b;
      logic [2:0] op;
      logic [7:0] res;
      logic       c, v, z;
   } vec_t;
   vec_t vecs[8];

   logic [9:0] exp_q[$];
   logic [9:0] got, expv;
   int         lat, ng, cyc;
   logic       exp_g[5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 8'hFF, 8'h01, OP_ADDU, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 8'h7F, 8'h01, OP_ADDS, 8'h80, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 8'h05, 8'h07, OP_SUBU, 8'hFE, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 8'hAA, 8'hFF, OP_XOR,  8'h55, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 8'h81, 8'h3C, OP_SHR1, 8'h40, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 8'h01, 8'h55, OP_SHR1, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 8'h0C, 8'h0A, OP_AND,  8'h08, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 8'h80, 8'h80, OP_ADDS, 8'h00, 1'b1, 1'b1, 1'b1};
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
      bus.req_a0 = '0; bus.req_b0 = '0; bus.req_op0 = '0;
      bus.req_a1 = '0; bus.req_b1 = '0; bus.req_op1 = '0;

      // Reset values
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_req_ready", bus.req_ready, 2'b00);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_id", bus.rsp_id, 1'b0);
      chk("rst_rsp_result", bus.rsp_result, 8'h00);
      chk("rst_rsp_flags", {bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero}, 3'b000);
      chk("rst_alu_regs", {alu_A, alu_B, alu_opcode}, 19'd0);
      chk("rst_state", dbg.state, ST_IDLE);
      chk("rst_ptr", dbg.ptr, 1'b0);

      // Simultaneous requests, held valid: grants 0,1,0,1,0
      bus.req_a0 = 8'h0F; bus.req_b0 = 8'hF0; bus.req_op0 = OP_AND;
      bus.req_a1 = 8'h0F; bus.req_b1 = 8'hF0; bus.req_op1 = OP_OR;
      bus.req_valid = 2'b11; bus.rsp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back({1'b0, 8'h00, 1'b1});
         exp_q.push_back({1'b1, 8'hFF, 1'b0});
      end
      #1;
      ng = 0; cyc = 0;
      while (ng < 5 && cyc < 80) begin
         if (bus.req_ready != 2'b00) begin
            chk($sformatf("sim_grant%0d", ng), bus.req_ready, exp_g[ng] ? 2'b10 : 2'b01);
            ng++;
         end
         if (bus.rsp_valid) begin
            got = {bus.rsp_id, bus.rsp_result, bus.rsp_zero};
            if (exp_q.size() == 0) chk("sim_rsp_extra", 32'(exp_q.size()), 32'd1);
            else begin
               expv = exp_q.pop_front();
               chk("sim_rsp", got, expv);
            end
         end
         if (ng < 5) begin
            @(negedge clk);
            cyc++;
         end
      end
      chk("sim_grant_count", ng, 5);
      chk("sim_rsp_left", exp_q.size(), 0);
      @(negedge clk);
      bus.req_valid = 2'b00;
`ifdef ALU_SHARE_STATS_EN
      chk("stats_cnt0", grant_cnt0, 16'd3);
      chk("stats_cnt1", grant_cnt1, 16'd2);
`endif
      drain();

      // Backpressure on a signed-add response
      @(negedge clk);
      bus.req_a1 = 8'h7F; bus.req_b1 = 8'h01; bus.req_op1 = OP_ADDS;
      bus.req_valid = 2'b10; bus.rsp_ready = 1'b0;
      #1;
      chk("bp_grant", bus.req_ready, 2'b10);
      @(negedge clk);
      bus.req_a0 = 8'h0C; bus.req_b0 = 8'h0A; bus.req_op0 = OP_AND;
      bus.req_valid = 2'b01;
      wait_rsp(lat);
      chk("bp_latency", lat, LAT + 1);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_valid", bus.rsp_valid, 1'b1);
         chk("bp_result", bus.rsp_result, 8'h80);
         chk("bp_overflow", bus.rsp_overflow, 1'b1);
         chk("bp_id", bus.rsp_id, 1'b1);
         chk("bp_req_ready", bus.req_ready, 2'b00);
         chk("bp_alu_a", alu_A, 8'h7F);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_next_state", dbg.state, ST_IDLE);
      chk("bp_next_grant", bus.req_ready, 2'b01);
      @(negedge clk);
      bus.req_valid = 2'b00;
      wait_rsp(lat);
      chk("bp_follow_rsp", {bus.rsp_id, bus.rsp_result}, {1'b0, 8'h08});
      drain();

      // Table of single operations, alternating requesters
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         bus.rsp_ready = 1'b1;
         if (vecs[k].id) begin
            bus.req_a1 = vecs[k].a; bus.req_b1 = vecs[k].b; bus.req_op1 = vecs[k].op;
            bus.req_a0 = ~vecs[k].a; bus.req_b0 = ~vecs[k].b; bus.req_op0 = ~vecs[k].op;
            bus.req_valid = 2'b10;
         end else begin
            bus.req_a0 = vecs[k].a; bus.req_b0 = vecs[k].b; bus.req_op0 = vecs[k].op;
            bus.req_a1 = ~vecs[k].a; bus.req_b1 = ~vecs[k].b; bus.req_op1 = ~vecs[k].op;
            bus.req_valid = 2'b01;
         end
         #1;
         chk($sformatf("vec%0d_grant", k), bus.req_ready, vecs[k].id ? 2'b10 : 2'b01);
         @(negedge clk);
         bus.req_valid = 2'b00;
         chk($sformatf("vec%0d_alu_in", k), {alu_A, alu_B, alu_opcode},
             {vecs[k].a, vecs[k].b, vecs[k].op});
         wait_rsp(lat);
         chk($sformatf("vec%0d_latency", k), lat, LAT + 1);
         chk($sformatf("vec%0d_result", k), bus.rsp_result, vecs[k].res);
         chk($sformatf("vec%0d_flags", k), {bus.rsp_carryout, bus.rsp_overflow, bus.rsp_zero},
             {vecs[k].c, vecs[k].v, vecs[k].z});
         chk($sformatf("vec%0d_id", k), bus.rsp_id, vecs[k].id);
         @(negedge clk);
         chk($sformatf("vec%0d_done", k), {dbg.state, bus.rsp_valid}, {ST_IDLE, 1'b0});
      end

      // Reset asserted while in WAIT
      @(negedge clk);
      bus.req_a0 = 8'h33; bus.req_b0 = 8'h11; bus.req_op0 = OP_SUBU;
      bus.req_valid = 2'b01; bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.req_valid = 2'b00;
      chk("mid_pre_state", dbg.state, ST_WAIT);
      chk("mid_pre_ptr", dbg.ptr, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rsp_valid", bus.rsp_valid, 1'b0);
      chk("mid_rsp_bus", {bus.rsp_id, bus.rsp_result, bus.rsp_carryout, bus.rsp_overflow,
                          bus.rsp_zero}, 12'd0);
      chk("mid_alu_regs", {alu_A, alu_B, alu_opcode}, 19'd0);
      chk("mid_state_ptr", {dbg.state, dbg.ptr}, {ST_IDLE, 1'b0});
`ifdef ALU_SHARE_STATS_EN
      chk("mid_stats", {grant_cnt0, grant_cnt1}, 32'd0);
`endif
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_hold_no_rsp", bus.rsp_valid, 1'b0);
      end
      rst_n = 1'b1;
      bus.req_a1 = 8'h0F; bus.req_b1 = 8'hF0; bus.req_op1 = OP_OR;
      bus.req_valid = 2'b10;
      #1;
      chk("mid_after_grant", bus.req_ready, 2'b10);
      @(negedge clk);
      bus.req_valid = 2'b00;
      wait_rsp(lat);
      chk("mid_after_rsp", {bus.rsp_id, bus.rsp_result, bus.rsp_zero}, {1'b1, 8'hFF, 1'b0});
      drain();
`ifdef ALU_SHARE_STATS_EN
      chk("end_cnt0", grant_cnt0, 16'd0);
      chk("end_cnt1", grant_cnt1, 16'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
